// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and alignment helper for the LSU controller
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ALIGN_HALF_MASK = 2'b01;
    localparam logic [1:0] ALIGN_WORD_MASK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } lsu_state_e;

    // Only the size bits of funct3 matter; unsigned variants share the signed rule.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1:0] == F3_H[1:0]) begin
            return (a & ALIGN_HALF_MASK) != 2'b00;
        end else if (f3[1:0] == F3_W[1:0]) begin
            return (a & ALIGN_WORD_MASK) != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// rtl/lsu_timeout_counter.sv - saturating cycle counter flagging a cache timeout
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    assign expired_o = (count_q == LIMIT);

    // Saturates so a handshake on the last allowed cycle still times out the response wait.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lsu_request_ctrl.sv
// rtl/lsu_request_ctrl.sv - MEM-stage to data-cache load/store handshake controller
module lsu_request_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        flush_i,
    output logic        dc_req_o,
    output logic        dc_we_o,
    output logic [31:0] dc_addr_o,
    output logic [31:0] dc_wdata_o,
    output logic [3:0]  dc_wstrb_o,
    input  logic        dc_ready_i,
    input  logic        dc_rvalid_i,
    input  logic [31:0] dc_rdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  addr_align_o,
    output logic [2:0]  funct3_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        bus_err_q, bus_err_d;

    logic access, misaligned, start, expired;

    assign access     = mem_valid_i & (is_load_i | is_store_i);
    assign misaligned = access & is_misaligned(funct3_i, addr_i[1:0]);
    assign start      = (state_q == ST_IDLE) & access & !misaligned & !flush_i;

    lsu_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == ST_IDLE),
        .enable_i  ((state_q == ST_REQ) || (state_q == ST_WAIT_RESP)),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wstrb_d   = wstrb_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    wstrb_d  = is_store_i ? wstrb_i : 4'b0000;
                    funct3_d = funct3_i;
                    we_d     = is_store_i;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    // An accepted store is already committed in the cache; only loads need draining.
                    state_d = (dc_ready_i && !we_q) ? ST_DRAIN : ST_IDLE;
                end else if (dc_ready_i) begin
                    state_d = we_q ? ST_DONE : ST_WAIT_RESP;
                end else if (expired) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT_RESP: begin
                if (flush_i) begin
                    state_d = dc_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (dc_rvalid_i) begin
                    rdata_d = dc_rdata_i;
                    state_d = ST_DONE;
                end else if (expired) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (dc_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                bus_err_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wstrb_q   <= wstrb_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dc_req_o     = (state_q == ST_REQ);
    assign dc_we_o      = we_q;
    assign dc_addr_o    = {addr_q[31:2], 2'b00};
    assign dc_wdata_o   = wdata_q;
    assign dc_wstrb_o   = wstrb_q;
    assign stall_o      = start | (state_q == ST_REQ) | (state_q == ST_WAIT_RESP) | (state_q == ST_DRAIN);
    assign done_o       = (state_q == ST_DONE);
    assign rdata_o      = rdata_q;
    assign addr_align_o = addr_q[1:0];
    assign funct3_o     = funct3_q;
    assign misaligned_o = (state_q == ST_IDLE) & misaligned;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_lsu_request_ctrl.sv
// tb/tb_lsu_request_ctrl.sv - directed self-checking bench for lsu_request_ctrl
module tb_lsu_request_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, is_load, is_store, flush;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        dc_ready, dc_rvalid;
    logic [31:0] dc_rdata;

    logic        req_a, we_a, stall_a, done_a, mis_a, berr_a;
    logic [31:0] daddr_a, dwdata_a, rdata_a;
    logic [3:0]  dwstrb_a;
    logic [1:0]  align_a;
    logic [2:0]  f3_a;

    logic        req_b, we_b, stall_b, done_b, mis_b, berr_b;
    logic [31:0] daddr_b, dwdata_b, rdata_b;
    logic [3:0]  dwstrb_b;
    logic [1:0]  align_b;
    logic [2:0]  f3_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_request_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .mem_valid_i(mem_valid), .is_load_i(is_load),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .wstrb_i(wstrb), .flush_i(flush), .dc_req_o(req_a), .dc_we_o(we_a),
        .dc_addr_o(daddr_a), .dc_wdata_o(dwdata_a), .dc_wstrb_o(dwstrb_a),
        .dc_ready_i(dc_ready), .dc_rvalid_i(dc_rvalid), .dc_rdata_i(dc_rdata),
        .stall_o(stall_a), .done_o(done_a), .rdata_o(rdata_a), .addr_align_o(align_a),
        .funct3_o(f3_a), .misaligned_o(mis_a), .bus_err_o(berr_a)
    );

    lsu_request_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .mem_valid_i(mem_valid), .is_load_i(is_load),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .wstrb_i(wstrb), .flush_i(flush), .dc_req_o(req_b), .dc_we_o(we_b),
        .dc_addr_o(daddr_b), .dc_wdata_o(dwdata_b), .dc_wstrb_o(dwstrb_b),
        .dc_ready_i(dc_ready), .dc_rvalid_i(dc_rvalid), .dc_rdata_i(dc_rdata),
        .stall_o(stall_b), .done_o(done_b), .rdata_o(rdata_b), .addr_align_o(align_b),
        .funct3_o(f3_b), .misaligned_o(mis_b), .bus_err_o(berr_b)
    );

    typedef struct {
        logic        valid;
        logic        ld;
        logic        st;
        logic        fl;
        logic [2:0]  f3;
        logic [31:0] a;
        logic        exp_mis;
        logic        exp_stall;
    } vec_t;

    vec_t vec [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        mem_valid = 1'b1;
        is_load   = ld;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        wstrb     = ws;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, F3_W,  32'h0000_2002, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, F3_H,  32'h0000_2002, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, F3_H,  32'h0000_2001, 1'b1, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, F3_W,  32'h0000_2000, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, F3_W,  32'h0000_1003, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, F3_B,  32'h0000_2003, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, F3_HU, 32'h0000_2003, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, F3_W,  32'h0000_2002, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, F3_W,  32'h0000_2002, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, F3_W,  32'h0000_2000, 1'b0, 1'b0};
        vec[10] = '{1'b1, 1'b0, 1'b1, 1'b0, F3_BU, 32'h0000_1002, 1'b0, 1'b1};

        rst = 1'b1; mem_valid = 0; is_load = 0; is_store = 0; flush = 0;
        funct3 = 0; addr = 0; wdata = 0; wstrb = 0;
        dc_ready = 0; dc_rvalid = 0; dc_rdata = 0;
        nxt(); nxt();
        rst = 1'b0;
        #1;
        check("rst_req", {31'b0, req_a}, 0);
        check("rst_stall", {31'b0, stall_a}, 0);
        check("rst_done", {31'b0, done_a}, 0);
        check("rst_rdata", rdata_a, 0);
        check("rst_addr", daddr_a, 0);
        check("rst_berr", {31'b0, berr_a}, 0);

        for (int i = 0; i < 11; i++) begin
            nxt();
            mem_valid = vec[i].valid; is_load = vec[i].ld; is_store = vec[i].st;
            flush = vec[i].fl; funct3 = vec[i].f3; addr = vec[i].a;
            #1;
            check($sformatf("tbl%0d_mis", i), {31'b0, mis_a}, {31'b0, vec[i].exp_mis});
            check($sformatf("tbl%0d_stall", i), {31'b0, stall_a}, {31'b0, vec[i].exp_stall});
            check($sformatf("tbl%0d_req", i), {31'b0, req_a}, 0);
            mem_valid = 0; flush = 0;
        end

        // SW, ready in the first REQ cycle
        nxt();
        issue(1'b0, 1'b1, F3_W, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
        dc_ready = 1'b1;
        #1;
        check("sw_stall0", {31'b0, stall_a}, 1);
        nxt(); mem_valid = 0; #1;
        check("sw_req", {31'b0, req_a}, 1);
        check("sw_addr", daddr_a, 32'h0000_1004);
        check("sw_we", {31'b0, we_a}, 1);
        check("sw_wstrb", {28'b0, dwstrb_a}, 32'hF);
        check("sw_wdata", dwdata_a, 32'hDEAD_BEEF);
        check("sw_done_early", {31'b0, done_a}, 0);
        nxt(); #1;
        check("sw_done", {31'b0, done_a}, 1);
        check("sw_done_stall", {31'b0, stall_a}, 0);
        check("sw_done_req", {31'b0, req_a}, 0);
        check("sw_berr", {31'b0, berr_a}, 0);
        dc_ready = 0;
        nxt(); #1;
        check("sw_done_pulse", {31'b0, done_a}, 0);

        // LB at 0x2003, ready on the third REQ cycle, rvalid two cycles later
        issue(1'b1, 1'b0, F3_B, 32'h0000_2003, 32'h0, 4'b1111);
        #1;
        nxt(); mem_valid = 0; #1;
        check("lb_req", {31'b0, req_a}, 1);
        check("lb_addr", daddr_a, 32'h0000_2000);
        check("lb_we", {31'b0, we_a}, 0);
        check("lb_wstrb", {28'b0, dwstrb_a}, 0);
        nxt(); #1;
        check("lb_req_held", {31'b0, req_a}, 1);
        nxt(); dc_ready = 1; #1;
        check("lb_req_hs", {31'b0, req_a}, 1);
        nxt(); dc_ready = 0; #1;
        check("lb_wait_req", {31'b0, req_a}, 0);
        check("lb_wait_stall", {31'b0, stall_a}, 1);
        nxt(); dc_rvalid = 1; dc_rdata = 32'h80FF_0000; #1;
        check("lb_wait_done", {31'b0, done_a}, 0);
        nxt(); dc_rvalid = 0; dc_rdata = 0; #1;
        check("lb_done", {31'b0, done_a}, 1);
        check("lb_rdata", rdata_a, 32'h80FF_0000);
        check("lb_align", {30'b0, align_a}, 3);
        check("lb_funct3", {29'b0, f3_a}, 0);
        check("lb_berr", {31'b0, berr_a}, 0);
        check("lb_stall", {31'b0, stall_a}, 0);

        // LW with ready at once and rvalid next cycle: done three cycles after issue
        nxt();
        issue(1'b1, 1'b0, F3_W, 32'h0000_6008, 32'h0, 4'b0000);
        dc_ready = 1;
        nxt(); mem_valid = 0;
        nxt(); dc_ready = 0; dc_rvalid = 1; dc_rdata = 32'h1234_5678; #1;
        check("lw_done_early", {31'b0, done_a}, 0);
        nxt(); dc_rvalid = 0; dc_rdata = 0; #1;
        check("lw_done", {31'b0, done_a}, 1);
        check("lw_rdata", rdata_a, 32'h1234_5678);
        check("lw_done_b", {31'b0, done_b}, 1);
        check("lw_rdata_b", rdata_b, 32'h1234_5678);

        // LW flushed in WAIT_RESP, response three cycles later is discarded
        nxt();
        issue(1'b1, 1'b0, F3_W, 32'h0000_5000, 32'h0, 4'b0000);
        dc_ready = 1;
        nxt(); mem_valid = 0;
        nxt(); dc_ready = 0; flush = 1; #1;
        check("fl_stall_wait", {31'b0, stall_a}, 1);
        nxt(); flush = 0; #1;
        check("fl_stall_d1", {31'b0, stall_a}, 1);
        check("fl_req_d1", {31'b0, req_a}, 0);
        check("fl_done_d1", {31'b0, done_a}, 0);
        nxt(); #1;
        check("fl_stall_d2", {31'b0, stall_a}, 1);
        nxt(); dc_rvalid = 1; dc_rdata = 32'hCAFE_F00D; #1;
        check("fl_stall_d3", {31'b0, stall_a}, 1);
        check("fl_done_d3", {31'b0, done_a}, 0);
        nxt(); dc_rvalid = 0; dc_rdata = 0; #1;
        check("fl_stall_idle", {31'b0, stall_a}, 0);
        check("fl_done_idle", {31'b0, done_a}, 0);
        check("fl_rdata", rdata_a, 32'h1234_5678);

        // Timeout on the 4-cycle instance, ready never asserted
        nxt();
        issue(1'b1, 1'b0, F3_W, 32'h0000_4000, 32'h0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            nxt(); mem_valid = 0; #1;
            check($sformatf("to_req%0d", k), {31'b0, req_b}, 1);
            check($sformatf("to_done%0d", k), {31'b0, done_b}, 0);
        end
        nxt(); #1;
        check("to_req_drop", {31'b0, req_b}, 0);
        check("to_done", {31'b0, done_b}, 1);
        check("to_berr", {31'b0, berr_b}, 1);
        check("to_rdata", rdata_b, 0);
        check("to_stall", {31'b0, stall_b}, 0);
        check("to_a_still_req", {31'b0, req_a}, 1);
        nxt(); #1;
        check("to_done_pulse", {31'b0, done_b}, 0);
        check("to_berr_clear", {31'b0, berr_b}, 0);
        rst = 1;
        nxt(); rst = 0;

        // Reset while in WAIT_RESP, then SB at 0x3001
        issue(1'b1, 1'b0, F3_W, 32'h0000_7004, 32'h0, 4'b0000);
        dc_ready = 1;
        nxt(); mem_valid = 0;
        nxt(); dc_ready = 0; #1;
        check("rw_stall", {31'b0, stall_a}, 1);
        rst = 1;
        nxt(); rst = 0; #1;
        check("rw_stall0", {31'b0, stall_a}, 0);
        check("rw_req0", {31'b0, req_a}, 0);
        check("rw_done0", {31'b0, done_a}, 0);
        check("rw_addr0", daddr_a, 0);
        check("rw_rdata0", rdata_a, 0);
        check("rw_f30", {29'b0, f3_a}, 0);
        issue(1'b0, 1'b1, F3_B, 32'h0000_3001, 32'hABAB_ABAB, 4'b0010);
        nxt(); mem_valid = 0; #1;
        check("sb_req", {31'b0, req_a}, 1);
        check("sb_wstrb", {28'b0, dwstrb_a}, 32'h2);
        check("sb_addr", daddr_a, 32'h0000_3000);
        check("sb_we", {31'b0, we_a}, 1);
        dc_ready = 1;
        nxt(); #1;
        check("sb_done", {31'b0, done_a}, 1);
        dc_ready = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
